// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment display blocks: blank patterns,
// the active-low glyph table and the digit index type.
package display_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; hex digits use the usual A b C d E F shapes.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [3:0] anode_select(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment decoder built on the shared
// glyph table; reusable by any display block.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = GLYPH_TABLE[nibble];

endmodule

// File: rtl/display_scan.sv
// Multiplexes a 4-digit common-anode 7-segment display, stepping one digit per
// refresh rising edge with anode-off guard time after each step.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module display_scan
    import display_pkg::*;
#(
    parameter logic [15:0] BLANK_CYCLES = 16'd1024,
    parameter int          NUM_DIGITS   = 4
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        refresh_in,
    input  logic        enable_in,
    input  logic [15:0] value_in,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output digit_idx_t  digit_idx
);

    localparam digit_idx_t IDX_MAX = digit_idx_t'(NUM_DIGITS - 1);

    logic        refresh_q;
    logic        rise;
    logic        scan_valid;
    logic [15:0] snapshot;
    logic [15:0] blank_cnt;
    digit_idx_t  next_idx;
    logic [3:0]  cur_nibble;
    logic [6:0]  cur_segments;
    logic        digit_hidden;

    assign rise       = refresh_in & ~refresh_q;
    assign next_idx   = (digit_idx == IDX_MAX) ? digit_idx_t'(0) : digit_idx + 2'd1;
    assign cur_nibble = snapshot[{digit_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble   (cur_nibble),
        .segments (cur_segments)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            refresh_q  <= 1'b1;
            digit_idx  <= 2'd3;
            snapshot   <= 16'h0000;
            blank_cnt  <= 16'd0;
            scan_valid <= 1'b0;
        end else begin
            refresh_q <= refresh_in;
            if (rise) begin
                digit_idx  <= next_idx;
                blank_cnt  <= BLANK_CYCLES;
                scan_valid <= 1'b1;
                // Whole frame comes from one capture, so a mid-frame value change cannot tear.
                if (next_idx == 2'd0) begin
                    snapshot <= value_in;
                end
            end else if (blank_cnt != 16'd0) begin
                blank_cnt <= blank_cnt - 16'd1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // NOTE: combinational block assigns a default first so no path infers a latch.
    always_comb begin
        digit_hidden = 1'b0;
        case (digit_idx)
            2'd3:    digit_hidden = (snapshot[15:12] == 4'h0);
            2'd2:    digit_hidden = (snapshot[15:8] == 8'h00);
            2'd1:    digit_hidden = (snapshot[15:4] == 12'h000);
            default: digit_hidden = 1'b0;
        endcase
    end
`else
    assign digit_hidden = 1'b0;
`endif

    // Outputs stay blank after reset until the first refresh advance selects digit 0.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            anodes   <= ANODE_OFF;
            segments <= SEG_BLANK;
        end else begin
            segments <= scan_valid ? cur_segments : SEG_BLANK;
            if (scan_valid && enable_in && (blank_cnt == 16'd0) && !digit_hidden) begin
                anodes <= anode_select(digit_idx);
            end else begin
                anodes <= ANODE_OFF;
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: a short-guard instance driven with a
// 40-cycle refresh and a long-guard instance whose guard outlasts its refresh.
module tb_display_scan;

    localparam int BLANK      = 4;
    localparam int BLANK_LONG = 30;

    typedef struct {
        logic [1:0] idx;
        logic [6:0] seg;
        logic [3:0] an;
    } exp_t;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        refresh_in = 1'b1;
    logic        refresh_long = 1'b1;
    logic        enable_in = 1'b1;
    logic [15:0] value_in = 16'h1234;
    logic [3:0]  anodes, anodes_l;
    logic [6:0]  segments, segments_l;
    logic [1:0]  digit_idx, digit_idx_l;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [1:0] exp_idx = 2'd3;

    always #5 clock_in = ~clock_in;

    display_scan #(.BLANK_CYCLES(16'(BLANK)), .NUM_DIGITS(4)) dut (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .refresh_in (refresh_in),
        .enable_in  (enable_in),
        .value_in   (value_in),
        .anodes     (anodes),
        .segments   (segments),
        .digit_idx  (digit_idx)
    );

    display_scan #(.BLANK_CYCLES(16'(BLANK_LONG)), .NUM_DIGITS(4)) dut_long (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .refresh_in (refresh_long),
        .enable_in  (enable_in),
        .value_in   (value_in),
        .anodes     (anodes_l),
        .segments   (segments_l),
        .digit_idx  (digit_idx_l)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Push the four expected digits of a frame captured from val.
    task automatic push_frame(input logic [15:0] val);
        logic [3:0] hidden;
        logic       seen;
        logic [3:0] an_tab [4];
        exp_t       e;
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        hidden = 4'b0000;
        seen   = 1'b0;
        for (int d = 3; d >= 1; d--) begin
            if (val[4*d +: 4] != 4'h0) seen = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            hidden[d] = !seen;
`endif
        end
        for (int d = 0; d < 4; d++) begin
            e.idx = 2'(d);
            e.seg = glyph(val[4*d +: 4]);
            e.an  = hidden[d] ? 4'b1111 : an_tab[d];
            sb.push_back(e);
        end
    endtask

    // One 40-cycle refresh period (20 high, 20 low); t counts edges from the rise edge k.
    task automatic scan_period(input int dis_t, input int en_t);
        exp_t e;
        if (exp_idx == 2'd3) push_frame(value_in);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 16'd0, 16'd1);
            return;
        end
        e = sb.pop_front();
        exp_idx = exp_idx + 2'd1;
        refresh_in = 1'b1;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (t == 0) check("digit_idx", 16'(digit_idx), 16'(e.idx));
            if (t == 1) begin
                check("segments", 16'(segments), 16'(e.seg));
                check("anodes_guard_first", 16'(anodes), 16'hF);
            end
            if (t == BLANK) check("anodes_guard_last", 16'(anodes), 16'hF);
            if (t == BLANK + 1) check("anodes_on", 16'(anodes), enable_in ? 16'(e.an) : 16'hF);
            if (dis_t >= 0 && t == dis_t + 1) check("anodes_disabled", 16'(anodes), 16'hF);
            if (en_t >= 0 && t == en_t + 1) check("anodes_reenabled", 16'(anodes), 16'(e.an));
            if (t == dis_t) enable_in = 1'b0;
            if (t == en_t) enable_in = 1'b1;
            if (t == 19) refresh_in = 1'b0;
        end
    endtask

    // Long-guard instance: rises every 20 cycles keep reloading a 30-cycle guard.
    task automatic long_guard_run();
        logic [1:0] long_idx = 2'd3;
        for (int r = 0; r < 12; r++) begin
            refresh_long = 1'b0;
            repeat (10) tick();
            refresh_long = 1'b1;
            tick();
            long_idx = long_idx + 2'd1;
            check("long_digit_idx", 16'(digit_idx_l), 16'(long_idx));
            for (int t = 0; t < 9; t++) begin
                tick();
                check("long_anodes_off", 16'(anodes_l), 16'hF);
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        check("reset_anodes", 16'(anodes), 16'hF);
        check("reset_segments", 16'(segments), 16'h7F);
        check("reset_digit_idx", 16'(digit_idx), 16'd3);
        reset_in = 1'b0;
        repeat (5) tick();
        check("post_reset_no_advance", 16'(digit_idx), 16'd3);
        check("post_reset_anodes", 16'(anodes), 16'hF);
        refresh_in = 1'b0;
        repeat (20) tick();

        fork
            begin
                repeat (3) scan_period(-1, -1);
                value_in = 16'hABCD;
                scan_period(-1, -1);
                scan_period(-1, -1);
                scan_period(10, -1);
                scan_period(-1, 20);
                scan_period(-1, -1);
                value_in = 16'h0070;
                repeat (4) scan_period(-1, -1);
                value_in = 16'h0000;
                repeat (4) scan_period(-1, -1);
            end
            long_guard_run();
        join

        refresh_in = 1'b1;
        repeat (3) tick();
        reset_in = 1'b1;
        tick();
        check("midscan_reset_anodes", 16'(anodes), 16'hF);
        check("midscan_reset_segments", 16'(segments), 16'h7F);
        check("midscan_reset_idx", 16'(digit_idx), 16'd3);
        reset_in = 1'b0;
        tick();
        check("after_reset_anodes", 16'(anodes), 16'hF);
        check("after_reset_segments", 16'(segments), 16'h7F);
        check("after_reset_idx", 16'(digit_idx), 16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
